an_grid_decoder_stream: RTL and testbench
=========================================

Name: an_grid_decoder_stream

Overview:
- Streaming, parametrised successor to the fixed 6x6 combinational AN-code grid decoder.
- Accepts ROWS*COLS AN-coded words, one per handshake, in row-major order, and buffers the whole grid.
- Per word: quotient by A, residue, and row/column error flags. Locates errored cells by row/column intersection, corrects them with single-bit AN arithmetic correction, then streams the messages out with per-word and per-grid status.

Parameters:
- A, 37, AN multiplier (odd). Distinct nonzero residues of ±2^k (k < CW_W) are a design precondition.
- CW_W, 18, codeword width.
- MSG_W, 13, message width; floor((2^CW_W-1)/A) < 2^MSG_W.
- R_W, 6, residue width; 2^R_W > A.
- ROWS, 6, grid rows (2..16).
- COLS, 6, grid columns (2..16).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  high in LOAD state only
- in_cw  in  CW_W  received codeword
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_msg  out  MSG_W  decoded or corrected message
- out_fixed  out  1  this word was corrected
- out_last  out  1  final word of grid
- grid_status  out  2  00 clean, 01 corrected, 10 uncorrectable; valid with out_last

Behaviour:
- Reset (rst_n=0 at posedge) aborts any operation from any state, discards the buffered grid, enters LOAD, and zeroes all counters and flags.
  - Output reset values: in_ready=1, out_valid=0, out_msg=0, out_fixed=0, out_last=0, grid_status=00.
- States: LOAD -> DECIDE -> FIX -> DRAIN -> LOAD.
- LOAD:
  - Each in_valid&in_ready stores the cell at index idx (0..ROWS*COLS-1): in_cw, q=in_cw/A (MSG_W bits), r=in_cw mod A (exact), err=(r!=0).
  - On err: sets row_err[idx/COLS] and col_err[idx%COLS].
  - Accepting the last cell moves to DECIDE next cycle with in_ready=0.
  - No input bubble penalty.
- DECIDE (1 cycle):
  - nr = popcount(row_err), nc = popcount(col_err).
  - nr=0 and nc=0: status clean, go to DRAIN.
  - nr=1 and nc=1: target = the intersection cell, go to FIX.
  - Any other combination: status uncorrectable, go to DRAIN, no cell modified.
- FIX (1 cycle per target cell):
  - Find k in [0,CW_W) with (2^k mod A)==r: corrected = cw - 2^k.
  - Else find k with (A - (2^k mod A))==r: corrected = cw + 2^k.
  - q := corrected/A, fixed flag set, status corrected.
  - No match, or corrected outside [0, 2^CW_W): status uncorrectable, cell left unchanged.
  - After the last target, go to DRAIN.
- DRAIN:
  - out_valid=1; words leave in row-major order; out_msg=q of the current cell.
  - Outputs hold stable while out_valid & !out_ready.
  - out_last=1 and grid_status valid on the final word.
  - After the final accepted word: LOAD, counters and flags cleared, in_ready=1 on the next cycle.
- Uncorrectable grid: every cell outputs its raw floor(cw/A); out_fixed=0 for all cells.
- Latency: last input accepted -> first out_valid = 2 cycles clean/uncorrectable, 2 + (number of targets) cycles when correcting.
- Simultaneous in_valid during DECIDE/FIX/DRAIN: ignored (in_ready=0).

Optional Feature:
- Macro: ANGRID_MULTI_FIX_EN.
- Defined: DECIDE also targets nr=1, nc>1 (every errored-column cell in the single errored row), and nc=1, nr>1 (every errored-row cell in the single errored column). Each target is then corrected as above. Only cells with err=1 are targeted.
- Undefined: those cases are uncorrectable.

Test Plan:
- Clean grid, ROWS=COLS=6, cell i = 37*(100+i) -> out_msg = 100..135 in order, all out_fixed=0, grid_status=00, first out_valid 2 cycles after the last input.
- Cell 14 = 3701 (msg 100, bit0 flipped, r=1) -> OUT14 msg=100, out_fixed=1 only on word 14, grid_status=01, latency 3.
- Cell 0 = 3696 (bit2 cleared, r=33=37-4) -> corrected to 3700, msg=100, grid_status=01.
- Errors in cells 7 and 28 (two rows, two columns) -> grid_status=10, messages = floor(cw/37), out_fixed=0 everywhere.
- Errors in cells 6 and 8 (row 1, cols 0 and 2):
  - Macro undefined -> status 10.
  - Macro defined -> both corrected, status 01.
- rst_n=0 while in DRAIN with out_ready=0 after word 10 -> next cycle out_valid=0, in_ready=1. A fresh clean grid then decodes correctly with no stale flags.

Source files
------------

// File: rtl/an_grid_decoder_stream_if.sv
// Stream handshake bundle for the AN-code grid decoder.
// The slave modport is the decoder side and the master modport is the producer/consumer side.
interface an_grid_decoder_stream_if #(
    parameter int CW_W  = 18,
    parameter int MSG_W = 13
);
    logic             in_valid;
    logic             in_ready;
    logic [CW_W-1:0]  in_cw;
    logic             out_valid;
    logic             out_ready;
    logic [MSG_W-1:0] out_msg;
    logic             out_fixed;
    logic             out_last;
    logic [1:0]       grid_status;

    modport slave (
        input  in_valid, in_cw, out_ready,
        output in_ready, out_valid, out_msg, out_fixed, out_last, grid_status
    );

    modport master (
        output in_valid, in_cw, out_ready,
        input  in_ready, out_valid, out_msg, out_fixed, out_last, grid_status
    );
endinterface

// File: rtl/an_grid_decoder_stream.sv
// Streaming AN-code grid decoder: buffer a ROWS x COLS grid, locate and correct single-bit errors, stream messages.
// Optional macro ANGRID_MULTI_FIX_EN also corrects several errored cells that share a single errored row or column.
module an_grid_decoder_stream #(
    parameter int A     = 37,
    parameter int CW_W  = 18,
    parameter int MSG_W = 13,
    parameter int R_W   = 6,
    parameter int ROWS  = 6,
    parameter int COLS  = 6
) (
    input  logic clk,
    input  logic rst_n,
    an_grid_decoder_stream_if.slave bus
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int K_W   = $clog2(CW_W);
    localparam int CNT_W = 5;
    localparam logic [CW_W-1:0] A_CW  = CW_W'(A);
    localparam logic [CW_W:0]   A_EXT = (CW_W+1)'(A);

    // state | meaning
    // LOAD   | accepting grid cells in row-major order
    // DECIDE | classify grid from row/column error flags
    // FIX    | correct one target cell per cycle
    // DRAIN  | stream messages out
    typedef enum logic [1:0] {S_LOAD, S_DECIDE, S_FIX, S_DRAIN} state_t;

    state_t r_state, w_next;

    logic [CW_W-1:0]  r_cw  [N];
    logic [MSG_W-1:0] r_q   [N];
    logic [MSG_W-1:0] r_qc  [N];
    logic [R_W-1:0]   r_res [N];
    logic [N-1:0]     r_err, r_fixed, r_tgt;
    logic [ROWS-1:0]  r_row_err;
    logic [COLS-1:0]  r_col_err;
    logic [IDX_W-1:0] r_idx;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [1:0]       r_status;

    logic             w_accept, w_idx_last, w_clean, w_fixable, w_use_fix, w_drain;
    logic [CNT_W-1:0] w_nr, w_nc;
    logic [MSG_W-1:0] w_in_q;
    logic [R_W-1:0]   w_in_r;
    logic [IDX_W-1:0] w_tgt;
    logic [N-1:0]     w_tgt_oh;
    logic [CW_W-1:0]  w_cw_t;
    logic [R_W-1:0]   w_r_t;
    logic             w_sub_hit, w_add_hit, w_fix_ok;
    logic [K_W-1:0]   w_k;
    logic [CW_W:0]    w_pk, w_cw_ext, w_corr;
    logic [MSG_W-1:0] w_qc;

    function automatic logic [R_W-1:0] pow_mod(input int k);
        logic [CW_W:0] p;
        p = (CW_W+1)'(1) << k;
        return R_W'(p % A_EXT);
    endfunction

    assign w_accept   = bus.in_valid && (r_state == S_LOAD);
    assign w_idx_last = (r_idx == IDX_W'(N-1));
    assign w_in_q     = MSG_W'(bus.in_cw / A_CW);
    assign w_in_r     = R_W'(bus.in_cw % A_CW);
    assign w_nr       = CNT_W'($countones(r_row_err));
    assign w_nc       = CNT_W'($countones(r_col_err));
    assign w_clean    = (w_nr == '0) && (w_nc == '0);
`ifdef ANGRID_MULTI_FIX_EN
    assign w_fixable  = (w_nr == CNT_W'(1)) || (w_nc == CNT_W'(1));
`else
    assign w_fixable  = (w_nr == CNT_W'(1)) && (w_nc == CNT_W'(1));
`endif

    always_comb begin
        w_tgt    = '0;
        w_tgt_oh = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (r_tgt[i]) w_tgt = IDX_W'(i);
        end
        w_tgt_oh[w_tgt] = 1'b1;
    end

    // Subtractive correction (bit was set by the error) takes priority over additive.
    always_comb begin
        w_cw_t    = r_cw[w_tgt];
        w_r_t     = r_res[w_tgt];
        w_sub_hit = 1'b0;
        w_add_hit = 1'b0;
        w_k       = '0;
        for (int k = 0; k < CW_W; k++) begin
            if (!w_sub_hit && (pow_mod(k) == w_r_t)) begin
                w_sub_hit = 1'b1;
                w_k       = K_W'(k);
            end
        end
        for (int k = 0; k < CW_W; k++) begin
            if (!w_sub_hit && !w_add_hit && ((R_W'(A) - pow_mod(k)) == w_r_t)) begin
                w_add_hit = 1'b1;
                w_k       = K_W'(k);
            end
        end
        w_pk     = (CW_W+1)'(1) << w_k;
        w_cw_ext = {1'b0, w_cw_t};
        w_corr   = w_sub_hit ? (w_cw_ext - w_pk) : (w_cw_ext + w_pk);
        w_fix_ok = (w_sub_hit && (w_cw_ext >= w_pk)) || (w_add_hit && !w_corr[CW_W]);
        w_qc     = MSG_W'(w_corr / A_EXT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:   if (w_accept && w_idx_last) w_next = S_DECIDE;
            S_DECIDE: w_next = (!w_clean && w_fixable) ? S_FIX : S_DRAIN;
            S_FIX:    if ((r_tgt & ~w_tgt_oh) == '0) w_next = S_DRAIN;
            S_DRAIN:  if (bus.out_ready && w_idx_last) w_next = S_LOAD;
            default:  w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err     <= '0;
            r_fixed   <= '0;
            r_tgt     <= '0;
            r_row_err <= '0;
            r_col_err <= '0;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_status  <= 2'b00;
        end else begin
            case (r_state)
                S_LOAD: if (w_accept) begin
                    r_cw[r_idx]    <= bus.in_cw;
                    r_q[r_idx]     <= w_in_q;
                    r_res[r_idx]   <= w_in_r;
                    r_err[r_idx]   <= (w_in_r != '0);
                    r_fixed[r_idx] <= 1'b0;
                    if (w_in_r != '0) begin
                        r_row_err[r_row] <= 1'b1;
                        r_col_err[r_col] <= 1'b1;
                    end
                    if (w_idx_last) begin
                        r_idx <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_col == COL_W'(COLS-1)) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                S_DECIDE: begin
                    if (w_clean) begin
                        r_status <= 2'b00;
                    end else if (w_fixable) begin
                        r_status <= 2'b01;
                        r_tgt    <= r_err;
                    end else begin
                        r_status <= 2'b10;
                    end
                end
                S_FIX: begin
                    r_tgt[w_tgt] <= 1'b0;
                    if (w_fix_ok) begin
                        r_qc[w_tgt]    <= w_qc;
                        r_fixed[w_tgt] <= 1'b1;
                    end else begin
                        r_status <= 2'b10;
                    end
                end
                S_DRAIN: if (bus.out_ready) begin
                    if (w_idx_last) begin
                        r_err     <= '0;
                        r_fixed   <= '0;
                        r_tgt     <= '0;
                        r_row_err <= '0;
                        r_col_err <= '0;
                        r_idx     <= '0;
                        r_status  <= 2'b00;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A failed correction anywhere makes the whole grid report raw quotients.
    assign w_drain   = (r_state == S_DRAIN);
    assign w_use_fix = r_fixed[r_idx] && (r_status != 2'b10);

    assign bus.in_ready    = (r_state == S_LOAD);
    assign bus.out_valid   = w_drain;
    assign bus.out_msg     = !w_drain ? '0 : (w_use_fix ? r_qc[r_idx] : r_q[r_idx]);
    assign bus.out_fixed   = w_drain && w_use_fix;
    assign bus.out_last    = w_drain && w_idx_last;
    assign bus.grid_status = (w_drain && w_idx_last) ? r_status : 2'b00;

endmodule

// File: tb/tb_an_grid_decoder_stream.sv
// Self-checking bench for an_grid_decoder_stream: grid-level reference model plus directed grids.
// Builds with or without ANGRID_MULTI_FIX_EN; the model follows the same macro.
module tb_an_grid_decoder_stream;
    localparam int P_A    = 37;
    localparam int P_CW   = 18;
    localparam int P_MSG  = 13;
    localparam int P_ROWS = 6;
    localparam int P_COLS = 6;
    localparam int N      = P_ROWS * P_COLS;

    logic clk;
    logic rst_n;

    an_grid_decoder_stream_if #(.CW_W(P_CW), .MSG_W(P_MSG)) bus ();

    an_grid_decoder_stream #(
        .A(P_A), .CW_W(P_CW), .MSG_W(P_MSG), .R_W(6), .ROWS(P_ROWS), .COLS(P_COLS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    longint g_cw [N];
    int     e_msg [N];
    int     e_fix [N];
    int     e_status;
    int     d_msg [N];
    int     d_fix [N];
    int     d_status;
    int     oidx;
    bit     chk_en;
    bit     stall_prev;
    int     prev_msg;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: classify grid from residues, correct targets with +-2^k search.
    function automatic void build_model();
        bit     rowf [P_ROWS];
        bit     colf [P_COLS];
        longint res [N];
        int     nr, nc, found;
        bit     fixable, fail;
        longint p, corr;
        for (int i = 0; i < P_ROWS; i++) rowf[i] = 1'b0;
        for (int i = 0; i < P_COLS; i++) colf[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            res[i]   = g_cw[i] % P_A;
            e_msg[i] = int'(g_cw[i] / P_A);
            e_fix[i] = 0;
            if (res[i] != 0) begin
                rowf[i / P_COLS] = 1'b1;
                colf[i % P_COLS] = 1'b1;
            end
        end
        nr = 0;
        nc = 0;
        for (int i = 0; i < P_ROWS; i++) nr += int'(rowf[i]);
        for (int i = 0; i < P_COLS; i++) nc += int'(colf[i]);
`ifdef ANGRID_MULTI_FIX_EN
        fixable = (nr == 1) || (nc == 1);
`else
        fixable = (nr == 1) && (nc == 1);
`endif
        if (nr == 0 && nc == 0) begin
            e_status = 0;
        end else if (!fixable) begin
            e_status = 2;
        end else begin
            fail = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (res[i] != 0) begin
                    found = 0;
                    corr  = 0;
                    for (int k = 0; k < P_CW; k++) begin
                        p = longint'(1) << k;
                        if (found == 0 && (p % P_A) == res[i]) begin
                            found = 1;
                            corr  = g_cw[i] - p;
                        end
                    end
                    for (int k = 0; k < P_CW; k++) begin
                        p = longint'(1) << k;
                        if (found == 0 && (P_A - (p % P_A)) == res[i]) begin
                            found = 2;
                            corr  = g_cw[i] + p;
                        end
                    end
                    if (found == 0 || corr < 0 || corr >= (longint'(1) << P_CW)) begin
                        fail = 1'b1;
                    end else begin
                        e_msg[i] = int'(corr / P_A);
                        e_fix[i] = 1;
                    end
                end
            end
            if (fail) begin
                e_status = 2;
                for (int i = 0; i < N; i++) begin
                    e_msg[i] = int'(g_cw[i] / P_A);
                    e_fix[i] = 0;
                end
            end else begin
                e_status = 1;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (stall_prev) begin
                chk("hold_valid", longint'(bus.out_valid), 1);
                chk("hold_msg", longint'(bus.out_msg), prev_msg);
            end
            if (bus.out_valid && bus.out_ready && oidx < N) begin
                chk($sformatf("msg[%0d]", oidx), longint'(bus.out_msg), e_msg[oidx]);
                chk($sformatf("fixed[%0d]", oidx), longint'(bus.out_fixed), e_fix[oidx]);
                chk($sformatf("last[%0d]", oidx), longint'(bus.out_last), (oidx == N-1) ? 1 : 0);
                d_msg[oidx] = int'(bus.out_msg);
                d_fix[oidx] = int'(bus.out_fixed);
                if (oidx == N-1) begin
                    chk("grid_status", longint'(bus.grid_status), e_status);
                    d_status = int'(bus.grid_status);
                end
                oidx++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_msg   = int'(bus.out_msg);
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic fill_clean();
        for (int i = 0; i < N; i++) g_cw[i] = longint'(P_A * (100 + i));
    endtask

    task automatic run_load(input string nm, input int lat_exp);
        int lat;
        build_model();
        oidx          = 0;
        d_status      = -1;
        chk_en        = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b1;
            bus.in_cw    = P_CW'(g_cw[i]);
            if (i == 0) begin
                @(negedge clk);
                chk({nm, "_in_ready"}, longint'(bus.in_ready), 1);
            end
            @(posedge clk);
            #1;
        end
        // keep offering junk while the decoder is busy; it must not be taken
        bus.in_cw = '1;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk({nm, "_latency"}, lat, lat_exp);
    endtask

    task automatic run_drain(input string nm, input bit stall, input int stop_at);
        int cyc;
        cyc = 0;
        while (oidx < stop_at && cyc < 2000) begin
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_words"}, oidx, stop_at);
        if (stop_at == N) begin
            chk({nm, "_back_in_ready"}, longint'(bus.in_ready), 1);
            chk({nm, "_back_out_valid"}, longint'(bus.out_valid), 0);
            chk_en = 1'b0;
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int sum_fix;
        rst_n         = 1'b0;
        chk_en        = 1'b0;
        stall_prev    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_cw     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_msg", longint'(bus.out_msg), 0);
        chk("rst_out_fixed", longint'(bus.out_fixed), 0);
        chk("rst_out_last", longint'(bus.out_last), 0);
        chk("rst_grid_status", longint'(bus.grid_status), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill_clean();
        run_load("clean", 2);
        run_drain("clean", 1'b0, N);
        chk("clean_msg0", d_msg[0], 100);
        chk("clean_msg35", d_msg[35], 135);
        chk("clean_status", d_status, 0);

        fill_clean();
        g_cw[14] = 3701;
        run_load("c14", 3);
        run_drain("c14", 1'b1, N);
        chk("c14_msg14", d_msg[14], 100);
        chk("c14_fix14", d_fix[14], 1);
        chk("c14_fix13", d_fix[13], 0);
        chk("c14_status", d_status, 1);

        fill_clean();
        g_cw[0] = 3696;
        run_load("c0", 3);
        run_drain("c0", 1'b0, N);
        chk("c0_msg0", d_msg[0], 100);
        chk("c0_fix0", d_fix[0], 1);
        chk("c0_status", d_status, 1);

        fill_clean();
        g_cw[7]  = longint'(P_A * 107 + 1);
        g_cw[28] = longint'(P_A * 128 + 2);
        run_load("two", 2);
        run_drain("two", 1'b1, N);
        chk("two_status", d_status, 2);
        chk("two_msg7", d_msg[7], 107);
        chk("two_msg28", d_msg[28], 128);
        chk("two_fix7", d_fix[7], 0);

        fill_clean();
        g_cw[6] = longint'(P_A * 106 + 1);
        g_cw[8] = longint'(P_A * 108 + 4);
`ifdef ANGRID_MULTI_FIX_EN
        run_load("row1", 4);
        run_drain("row1", 1'b0, N);
        chk("row1_status", d_status, 1);
        chk("row1_msg6", d_msg[6], 106);
        chk("row1_msg8", d_msg[8], 108);
        chk("row1_fix8", d_fix[8], 1);
`else
        run_load("row1", 2);
        run_drain("row1", 1'b0, N);
        chk("row1_status", d_status, 2);
        chk("row1_msg8", d_msg[8], 108);
        chk("row1_fix6", d_fix[6], 0);
`endif

        // abort mid-drain with a stalled consumer, then a fresh clean grid
        fill_clean();
        g_cw[7]  = longint'(P_A * 107 + 1);
        g_cw[28] = longint'(P_A * 128 + 2);
        run_load("abort", 2);
        run_drain("abort", 1'b0, 11);
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        chk("abort_out_valid", longint'(bus.out_valid), 0);
        chk("abort_in_ready", longint'(bus.in_ready), 1);
        chk("abort_out_last", longint'(bus.out_last), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_clean();
        run_load("fresh", 2);
        run_drain("fresh", 1'b1, N);
        chk("fresh_status", d_status, 0);
        chk("fresh_msg10", d_msg[10], 110);
        sum_fix = 0;
        for (int i = 0; i < N; i++) sum_fix += d_fix[i];
        chk("fresh_no_fixed", sum_fix, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
